// File: rtl/activate_all_seq_pkg.sv
// Shared activation helpers for the forward (gdo_act_*) and backward (gdo_diff_*) passes,
// plus the sequencer state type. Arithmetic is done on 32-bit signed values.
package gdo;

    localparam int unsigned LINEAR  = 32'd0;
    localparam int unsigned BINARY  = 32'd1;
    localparam int unsigned SIGMOID = 32'd2;
    localparam int unsigned TANH    = 32'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } act_seq_state_t;

    function automatic logic signed [31:0] gdo_one(input int unsigned fb);
        return 32'sd1 <<< fb;
    endfunction

    function automatic logic signed [31:0] gdo_act_linear(input logic signed [31:0] x,
                                                          input int unsigned fb);
        logic unused_fb;
        unused_fb = ^fb;
        return x;
    endfunction

    function automatic logic signed [31:0] gdo_act_binary(input logic signed [31:0] x,
                                                          input int unsigned fb);
        return (x >= 32'sd0) ? gdo_one(fb) : 32'sd0;
    endfunction

    // Hard sigmoid: x/4 + 0.5, clamped to [0, 1].
    function automatic logic signed [31:0] gdo_act_sigmoid(input logic signed [31:0] x,
                                                           input int unsigned fb);
        logic signed [31:0] t;
        t = (x >>> 2) + (32'sd1 <<< (fb - 32'd1));
        if (t < 32'sd0) begin
            return 32'sd0;
        end else if (t > gdo_one(fb)) begin
            return gdo_one(fb);
        end else begin
            return t;
        end
    endfunction

    function automatic logic signed [31:0] gdo_act_tanh(input logic signed [31:0] x,
                                                        input int unsigned fb);
        if (x < -gdo_one(fb)) begin
            return -gdo_one(fb);
        end else if (x > gdo_one(fb)) begin
            return gdo_one(fb);
        end else begin
            return x;
        end
    endfunction

    function automatic logic signed [31:0] gdo_diff_linear(input logic signed [31:0] x,
                                                           input int unsigned fb);
        logic unused_x;
        unused_x = ^x;
        return gdo_one(fb);
    endfunction

    function automatic logic signed [31:0] gdo_diff_binary(input logic signed [31:0] x,
                                                           input int unsigned fb);
        logic unused_in;
        unused_in = ^{x, fb};
        return 32'sd0;
    endfunction

    // Slope 1/4 inside the linear region x in [-2, 2], flat outside.
    function automatic logic signed [31:0] gdo_diff_sigmoid(input logic signed [31:0] x,
                                                            input int unsigned fb);
        if ((x >= -(gdo_one(fb) <<< 1)) && (x <= (gdo_one(fb) <<< 1))) begin
            return gdo_one(fb) >>> 2;
        end else begin
            return 32'sd0;
        end
    endfunction

    function automatic logic signed [31:0] gdo_diff_tanh(input logic signed [31:0] x,
                                                         input int unsigned fb);
        if ((x >= -gdo_one(fb)) && (x <= gdo_one(fb))) begin
            return gdo_one(fb);
        end else begin
            return 32'sd0;
        end
    endfunction

endpackage

// File: rtl/activate_all_seq_act_select.sv
// Combinational single-element activation: applies the selected forward function.
module act_select
    import gdo::*;
#(
    parameter int unsigned data_size     = 16,
    parameter int unsigned act_type_size = 4,
    parameter int unsigned frac_bits     = 8
) (
    input  logic [data_size-1:0]     elem_i,
    input  logic [act_type_size-1:0] act_type_i,
    output logic [data_size-1:0]     elem_o
);

    logic signed [31:0] wide_s;

    assign wide_s = {{(32-data_size){elem_i[data_size-1]}}, elem_i};

    // Unknown selector codes fall back to LINEAR.
    always_comb begin
        elem_o = elem_i;
        case (int'(act_type_i))
            LINEAR:  elem_o = data_size'(gdo_act_linear(wide_s, frac_bits));
            BINARY:  elem_o = data_size'(gdo_act_binary(wide_s, frac_bits));
            SIGMOID: elem_o = data_size'(gdo_act_sigmoid(wide_s, frac_bits));
            TANH:    elem_o = data_size'(gdo_act_tanh(wide_s, frac_bits));
            default: elem_o = data_size'(gdo_act_linear(wide_s, frac_bits));
        endcase
    end

endmodule

// File: rtl/activate_all_seq.sv
// Serial forward-activation engine: latches a packed vector, activates one element per
// cycle through a two-stage pipeline and returns the packed result over valid/ready.
module activate_all_seq
    import gdo::*;
#(
    parameter int unsigned size          = 3,
    parameter int unsigned data_size     = 16,
    parameter int unsigned act_type_size = 4,
    parameter int unsigned frac_bits     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [size*data_size-1:0] x,
    input  logic [act_type_size-1:0]  act_type,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [size*data_size-1:0] y,
    output logic                      busy
);

    localparam int unsigned CW = (size > 1) ? $clog2(size) : 1;

    act_seq_state_t             state_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic [size*data_size-1:0]  x_q;
    logic [act_type_size-1:0]   at_q;
    logic [CW-1:0]              cnt_q;

    logic [data_size-1:0]       elem_s;
    logic [data_size-1:0]       act_s;
    logic [data_size-1:0]       val_q;
    logic [CW-1:0]              idx_q;
    logic                       va_q;
    logic [size*data_size-1:0]  y_q;
    logic [size*data_size-1:0]  y_d;

    // Sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            x_q         <= '0;
            at_q        <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= x;
                        at_q       <= act_type;
                        cnt_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(size - 1)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Element k sits in the MSB-first packed layout.
    always_comb begin
        elem_s = '0;
        for (int k = 0; k < int'(size); k++) begin
            elem_s = (cnt_q == CW'(k)) ? x_q[(int'(size)-k)*int'(data_size)-1 -: data_size] : elem_s;
        end
    end

    act_select #(
        .data_size     (data_size),
        .act_type_size (act_type_size),
        .frac_bits     (frac_bits)
    ) u_act_select (
        .elem_i     (elem_s),
        .act_type_i (at_q),
        .elem_o     (act_s)
    );

    // Stage B: drop the registered element into its slot; other slots keep old values.
    always_comb begin
        y_d = y_q;
        for (int k = 0; k < int'(size); k++) begin
            y_d[(int'(size)-k)*int'(data_size)-1 -: data_size] =
                (va_q && (idx_q == CW'(k))) ? val_q
                                             : y_q[(int'(size)-k)*int'(data_size)-1 -: data_size];
        end
    end

    // Stage A register and result vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
            idx_q <= '0;
            va_q  <= 1'b0;
            y_q   <= '0;
        end else begin
            y_q <= y_d;
            if (state_q == RUN) begin
                val_q <= act_s;
                idx_q <= cnt_q;
                va_q  <= 1'b1;
            end else begin
                va_q  <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign y         = y_q;

endmodule

// File: tb/tb_activate_all_seq.sv
// Randomized self-checking bench for activate_all_seq against a plain-arithmetic model.
module tb_activate_all_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] x;
    logic [3:0]  act_type;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] y;
    logic        busy;

    int n_checks;
    int n_pass;

    activate_all_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .act_type  (act_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: Q8.8 activation on one element, plain integer arithmetic.
    function automatic int ref_elem(input int at, input int e);
        int q;
        int t;
        case (at)
            1: return (e >= 0) ? 256 : 0;
            2: begin
                q = (e >= 0) ? (e / 4) : -((-e + 3) / 4);
                t = q + 128;
                if (t < 0) return 0;
                if (t > 256) return 256;
                return t;
            end
            3: begin
                if (e < -256) return -256;
                if (e > 256) return 256;
                return e;
            end
            default: return e;
        endcase
    endfunction

    function automatic logic [47:0] ref_vec(input int at, input logic [47:0] xv);
        logic [47:0] r;
        logic [15:0] s;
        int e;
        int o;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            s = xv[(3-k)*16-1 -: 16];
            e = int'($signed(s));
            o = ref_elem(at, e);
            r[(3-k)*16-1 -: 16] = o[15:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        if (r[31:30] == 2'b00) return r[15:0];
        return 16'(int'($urandom_range(0, 2400)) - 1200);
    endfunction

    // Run one vector; hold = cycles of backpressure in DONE.
    task automatic run_vec(input string tag, input int at, input logic [47:0] xv, input int hold);
        logic [47:0] expv;
        int n;
        expv = ref_vec(at, xv);
        @(negedge clk);
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        x        = xv;
        act_type = 4'(at);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        x        = {rand_elem(), rand_elem(), rand_elem()};
        act_type = 4'($urandom_range(0, 15));
        check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            check({tag, "_busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_y"}, 64'(y), 64'(expv));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            x        = {rand_elem(), rand_elem(), rand_elem()};
            act_type = 4'($urandom_range(0, 15));
            @(negedge clk);
            check({tag, "_bp_y"}, 64'(y), 64'(expv));
            check({tag, "_bp_out_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [47:0] xv;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        act_type = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_vec("linear",  0, {16'h0300, 16'hFE00, 16'h0000}, 0);
        check("linear_lit", 64'(y), 64'h0000_0300_FE00_0000);
        run_vec("binary",  1, {16'h0001, 16'hFFFF, 16'h0000}, 0);
        run_vec("sigmoid", 2, {16'h0000, 16'h0100, 16'hF800}, 0);
        check("sigmoid_lit", 64'(y), 64'h0000_0080_00C0_0000);
        run_vec("sig_clamp", 2, {16'h0400, 16'h0100, 16'hF800}, 0);
        run_vec("tanh",    3, {16'h0080, 16'h0200, 16'h8000}, 0);
        check("tanh_lit", 64'(y), 64'h0000_0080_0100_FF00);
        run_vec("type7",   7, {16'h0080, 16'h0200, 16'h8000}, 5);
        run_vec("after_bp", 1, {16'h8000, 16'h7FFF, 16'h0100}, 0);

        // Reset mid-RUN: outputs clear without waiting for an edge.
        @(negedge clk);
        in_valid = 1'b1;
        x        = {16'h0100, 16'h0200, 16'h0300};
        act_type = 4'd0;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_y", 64'(y), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arst_no_stray_ov", 64'(out_valid), 64'd0);
            check("arst_idle_ready", 64'(in_ready), 64'd1);
        end
        run_vec("post_rst_bin", 1, {16'hFF00, 16'h0000, 16'h1234}, 0);

        for (int i = 0; i < 14; i++) begin
            xv = {rand_elem(), rand_elem(), rand_elem()};
            run_vec("rand", int'($urandom_range(0, 15)), xv, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/activate_all_seq.md
Name: activate_all_seq

Overview:
- Forward-pass companion to the backward-pass activation-derivative block.
- Accepts one packed vector of `size` fixed-point elements and applies the selected activation function to each element serially, one element per cycle, through a 2-stage pipeline.
- Returns the full packed result vector over a valid/ready handshake.
- Sits between a neuron-layer accumulator and the next layer's input buffer.

Parameters:
- size, 3, number of elements per vector
- data_size, 16, bits per element; signed two's complement fixed point
- act_type_size, 4, width of the activation selector
- frac_bits, 8, fractional bits per element; 1.0 = 1<<frac_bits (Q8.8 at defaults)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  x and act_type are valid
- in_ready  output  1  block can accept a vector
- x  input  size*data_size  packed input; element k = x[(size-k)*data_size-1 -: data_size], element 0 in the MSBs
- act_type  input  act_type_size  0=LINEAR, 1=BINARY, 2=SIGMOID, 3=TANH, any other value=LINEAR
- out_valid  output  1  y holds a complete result
- out_ready  input  1  consumer accepts y
- y  output  size*data_size  packed result, same element layout as x
- busy  output  1  high in RUN or DRAIN

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - y=0, internal vector/act_type latches=0, element counter=0, pipeline valid=0.
  - Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0: latch x and act_type, counter=0, go to RUN.
  - RUN: stage A evaluates element[counter] with the latched act_type and registers {value, index, valid=1}. Counter increments.
  - RUN exit: on the edge that processes element size-1, go to DRAIN.
  - DRAIN: stage B writes the last element into y, then go to DONE.
  - DONE: out_valid=1. On out_valid&&out_ready, go to IDLE; out_valid drops on that edge.
- Stage B (every edge with stage-A valid=1) writes the registered value into slot `index` of y.
- Latency: stage A runs on edges E1..E_size and stage B on E2..E_(size+1). out_valid is high after E_(size+1) (4 edges at size=3).
- Throughput: one vector per size+2 cycles plus handshake cycles.
- in_ready is high only in IDLE. in_valid in any other state is ignored. Changes to x or act_type after acceptance have no effect.
- y is stable for the entire time out_valid=1. Slots are written only during RUN/DRAIN and keep the previous vector's values until overwritten.
- Arithmetic, with one = 1<<frac_bits and half = 1<<(frac_bits-1):
  - LINEAR: y=x.
  - BINARY: x>=0 gives one, else 0.
  - SIGMOID (hard sigmoid): t = (x>>>2) + half, computed at data_size+1 bits so it cannot overflow; clamp t to [0, one].
  - TANH (hard tanh): clamp x to [-one, +one].
- At IDLE→accept there is no bypass: the output is never combinationally derived from x.

Decomposition:
- Package gdo:
  - activation-code localparams LINEAR/BINARY/SIGMOID/TANH.
  - Forward functions gdo_act_linear, gdo_act_binary, gdo_act_sigmoid, gdo_act_tanh, defined alongside the existing gdo_diff_* functions.
  - State enum typedef act_seq_state_t {IDLE, RUN, DRAIN, DONE}.
- Sub-module act_select: purely combinational, one element in, act_type in, activated element out. Uses the gdo functions; instantiated once in stage A.

Test Plan:
- LINEAR: x={0x0300,0xFE00,0x0000} -> y={0x0300,0xFE00,0x0000}; out_valid exactly 4 edges after accept; busy high for edges 1–3.
- BINARY: x={0x0001,0xFFFF,0x0000} -> y={0x0100,0x0000,0x0100}.
- SIGMOID: x={0x0000,0x0100,0xF800} -> y={0x0080,0x00C0,0x0000}. A second vector {0x0400,...} -> element 0 = 0x0100 (upper clamp).
- TANH then act_type=7:
  - TANH x={0x0080,0x0200,0x8000} -> y={0x0080,0x0100,0xFF00}.
  - act_type=7, same x -> y unchanged from x (LINEAR).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 and toggling x/act_type -> y and out_valid stay stable, in_ready=0, nothing accepted; after out_ready=1 the next vector is accepted in IDLE.
- Reset mid-RUN (after 2nd edge): all outputs read 0 immediately while reset is high (asynchronous, not on the next edge); in_ready=1 after release; no stray out_valid; the next BINARY vector produces the correct result.
